fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem read at a time, a 2-entry
// instruction queue, and redirect/exception handling that kills an in-flight read.
module fetch_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_3000,
  parameter logic [31:0] EXC_ADDR   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:2] redirect_pc,
  input  logic        exc_valid,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:2] inst_pc,
  output logic [31:2] pc
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, KILL = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:2] pc_d;
  logic [31:2] tgt_q, tgt_d;
  logic [31:2] target;
  logic        pend_q, pend_d;
  logic [1:0]  count_q, count_after_pop;
  logic [31:0] q_data [2];
  logic [31:2] q_pc   [2];
  logic        flush, pop, push, wr_idx;

  // Exception outranks redirect; either one empties the queue.
  assign flush  = exc_valid | redirect_valid;
  assign target = exc_valid ? EXC_ADDR[31:2] : redirect_pc;

  assign pop             = inst_valid & ~stall;
  assign count_after_pop = count_q - {1'b0, pop};
  assign wr_idx          = count_after_pop[0];

  assign imem_addr  = pc;
  assign inst_valid = (count_q != 2'd0);
  assign inst       = q_data[0];
  assign inst_pc    = q_pc[0];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    pc_d     = pc;
    tgt_d    = tgt_q;
    pend_d   = pend_q;
    push     = 1'b0;
    imem_req = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (flush) pc_d = target;
      end
      FETCH: begin
        imem_req = pend_q | (count_after_pop <= 2'd1);
        if (flush) begin
          if (imem_req && !imem_ack) begin
            // The read already on the bus must complete before pc may move.
            tgt_d   = target;
            pend_d  = 1'b1;
            state_d = KILL;
          end else begin
            pc_d   = target;
            pend_d = 1'b0;
          end
        end else if (imem_req && imem_ack) begin
          push   = 1'b1;
          pc_d   = pc + 30'd1;
          pend_d = 1'b0;
        end else begin
          pend_d = imem_req;
        end
      end
      KILL: begin
        imem_req = 1'b1;
        if (flush) tgt_d = target;
        if (imem_ack) begin
          pc_d    = flush ? target : tgt_q;
          pend_d  = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= IDLE;
      pc      <= RESET_ADDR[31:2];
      tgt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the queue slots are reset, unlike a RAM, because inst/inst_pc must read zero in reset.
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      if (pop) begin
        q_data[0] <= q_data[1];
        q_pc[0]   <= q_pc[1];
      end
      // A push lands behind whatever survives this cycle's pop.
      if (push) begin
        q_data[wr_idx] <= imem_rdata;
        q_pc[wr_idx]   <= pc;
      end
      count_q <= count_after_pop + {1'b0, push};
    end
  end

  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    imem_req && !imem_ack |=> imem_req && $stable(imem_addr));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> count_after_pop != 2'd2);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_sequencer;

  localparam logic [29:0] RESET_W = 30'h0000_0C00;
  localparam logic [29:0] EXC_W   = 30'h0000_1060;

  typedef struct {
    logic [31:0] data;
    logic [29:0] addr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:2] redirect_pc = '0;
  logic        exc_valid = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:2] imem_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:2] inst_pc;
  logic [31:2] pc;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .pc             (pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  entry_t      m_q[$];
  logic        m_idle = 1'b1;
  logic        m_kill = 1'b0;
  logic        m_pend = 1'b0;
  logic [29:0] m_pc   = RESET_W;
  logic [29:0] m_tgt  = '0;

  // Memory responder state
  int   lat = 1;
  int   busy = 0;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;

  logic [29:0] deliv_pc[$];
  logic [31:0] deliv_inst[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [29:0] a);
    return {a, 2'b00} ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic model_req();
    int eff;
    if (m_idle) return 1'b0;
    if (m_kill) return 1'b1;
    eff = m_q.size() - ((m_q.size() > 0 && !stall) ? 1 : 0);
    return m_pend || (eff <= 1);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_idle = 1'b1;
    m_kill = 1'b0;
    m_pend = 1'b0;
    m_pc   = RESET_W;
    m_tgt  = '0;
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    logic        flush, req, do_pop;
    logic [29:0] target;
    flush  = exc_valid || redirect_valid;
    target = exc_valid ? EXC_W : redirect_pc;
    do_pop = (m_q.size() > 0) && !stall;
    req    = model_req();
    if (m_idle) begin
      m_idle = 1'b0;
      if (flush) begin
        m_q.delete();
        m_pc = target;
      end
    end else if (m_kill) begin
      if (flush) m_tgt = target;
      if (imem_ack) begin
        m_pc   = m_tgt;
        m_kill = 1'b0;
        m_pend = 1'b0;
      end
    end else if (flush) begin
      m_q.delete();
      if (req && !imem_ack) begin
        m_tgt  = target;
        m_kill = 1'b1;
        m_pend = 1'b1;
      end else begin
        m_pc   = target;
        m_pend = 1'b0;
      end
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (req && imem_ack) begin
        m_q.push_back('{data: imem_rdata, addr: m_pc});
        m_pc   = m_pc + 30'd1;
        m_pend = 1'b0;
      end else begin
        m_pend = req;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic er;
      er = model_req();
      check("imem_req", 32'(imem_req), 32'(er));
      if (er) check("imem_addr", 32'(imem_addr), 32'(m_pc));
      check("pc", 32'(pc), 32'(m_pc));
      check("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        check("inst", inst, m_q[0].data);
        check("inst_pc", 32'(inst_pc), 32'(m_q[0].addr));
      end
      if (inst_valid && !stall) begin
        deliv_pc.push_back(inst_pc);
        deliv_inst.push_back(inst);
      end
    end
  end

  // One clock: step the model, then present the new cycle's inputs and memory response.
  task automatic drive(input logic s, input logic r, input logic [29:0] rp, input logic e);
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
    busy = prev_ack ? 0 : (prev_req ? busy + 1 : 0);
    stall          = s;
    redirect_valid = r;
    redirect_pc    = rp;
    exc_valid      = e;
    imem_ack       = 1'b0;
    #1;
    imem_ack   = imem_req && (busy >= lat);
    imem_rdata = imem_ack ? mem(imem_addr) : 32'h0;
    #1;
    prev_req = imem_req;
    prev_ack = imem_ack;
  endtask

  // Assert reset at the current time (possibly mid-cycle) and release it on a later edge.
  task automatic apply_reset_now();
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    exc_valid      = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    model_reset();
    busy     = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'h0000_0C00);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", 32'(inst_pc), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("idle_req", 32'(imem_req), 32'd0);
  endtask

  task automatic next_req_after_ack(input logic [29:0] exp, input string name);
    bit seen_ack = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (seen_ack && imem_req) begin
        check(name, 32'(imem_addr), 32'(exp));
        done = 1'b1;
      end else begin
        if (imem_ack) seen_ack = 1'b1;
        drive(1'b0, 1'b0, 30'h0, 1'b0);
      end
    end
    check({name, "_found"}, 32'(done), 32'd1);
  endtask

  task automatic next_clean_req(input logic [29:0] exp, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      drive(1'b0, 1'b0, 30'h0, 1'b0);
      if (!m_kill && imem_req) begin
        check(name, 32'(imem_addr), 32'(exp));
        done = 1'b1;
      end
    end
    check({name, "_found"}, 32'(done), 32'd1);
  endtask

  // Redirect onto a freshly raised request whose ack arrives 3 cycles later.
  task automatic kill_scenario(input logic [29:0] t1, input bit second,
                               input logic [29:0] t2, input string name);
    bit          found = 1'b0;
    logic [29:0] old;
    lat = 3;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 1'b0, 30'h0, 1'b0);
      if (imem_req && !imem_ack && busy == 0) found = 1'b1;
    end
    check({name, "_arm"}, 32'(found), 32'd1);
    old = m_pc;
    drive(1'b0, 1'b1, t1, 1'b0);
    drive(1'b0, second, t2, 1'b0);
    check({name, "_kill_req"}, 32'(imem_req), 32'd1);
    check({name, "_kill_addr"}, 32'(imem_addr), 32'(old));
    check({name, "_kill_valid"}, 32'(inst_valid), 32'd0);
    next_req_after_ack(second ? t2 : t1, {name, "_target"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start;
    #2 apply_reset_now();
    drive(1'b0, 1'b0, 30'h0, 1'b0);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'h0000_0C00);

    // Streaming with one-cycle memory latency
    lat = 1;
    repeat (10) drive(1'b0, 1'b0, 30'h0, 1'b0);
    check("deliv_ge3", 32'(deliv_pc.size() >= 3), 32'd1);
    if (deliv_pc.size() >= 3) begin
      check("seq0", 32'(deliv_pc[0]), 32'h0000_0C00);
      check("seq1", 32'(deliv_pc[1]), 32'h0000_0C01);
      check("seq2", 32'(deliv_pc[2]), 32'h0000_0C02);
      check("inst0", deliv_inst[0], 32'hDEAD_8EEF);
    end

    // Stall long enough to fill the queue, then drain
    repeat (6) drive(1'b1, 1'b0, 30'h0, 1'b0);
    check("stall_full_valid", 32'(inst_valid), 32'd1);
    check("stall_full_req", 32'(imem_req), 32'd0);
    repeat (8) drive(1'b0, 1'b0, 30'h0, 1'b0);
    check("deliv_ge6", 32'(deliv_pc.size() >= 6), 32'd1);
    for (int i = 0; i < deliv_pc.size(); i++)
      check("seq_cont", 32'(deliv_pc[i]), 32'h0000_0C00 + 32'(i));

    // Redirect against an in-flight read, then latest-wins inside KILL
    kill_scenario(30'h0000_0D00, 1'b0, 30'h0, "redir");
    kill_scenario(30'h0000_0E00, 1'b1, 30'h0000_0E80, "redir2");
    repeat (4) drive(1'b0, 1'b0, 30'h0, 1'b0);

    // Exception and redirect together: exception vector wins
    lat = 1;
    repeat (3) drive(1'b0, 1'b0, 30'h0, 1'b0);
    drive(1'b0, 1'b1, 30'h0000_0555, 1'b1);
    next_clean_req(EXC_W, "exc_prio");
    repeat (4) drive(1'b0, 1'b0, 30'h0, 1'b0);

    // pc wrap at the top of the word address space
    drive(1'b0, 1'b1, 30'h3FFF_FFFF, 1'b0);
    next_clean_req(30'h3FFF_FFFF, "wrap_top");
    next_req_after_ack(30'h0, "wrap_zero");
    repeat (4) drive(1'b0, 1'b0, 30'h0, 1'b0);

    // Reset while a request is live and the queue is full
    repeat (6) drive(1'b1, 1'b0, 30'h0, 1'b0);
    drive(1'b0, 1'b0, 30'h0, 1'b0);
    check("pre_rst_req", 32'(imem_req), 32'd1);
    check("pre_rst_valid", 32'(inst_valid), 32'd1);
    start = deliv_pc.size();
    apply_reset_now();
    drive(1'b0, 1'b0, 30'h0, 1'b0);
    check("rerun_req", 32'(imem_req), 32'd1);
    check("rerun_addr", 32'(imem_addr), 32'h0000_0C00);
    repeat (6) drive(1'b0, 1'b0, 30'h0, 1'b0);
    check("rerun_deliv", 32'(deliv_pc.size() > start), 32'd1);
    if (deliv_pc.size() > start)
      check("rerun_first_pc", 32'(deliv_pc[start]), 32'h0000_0C00);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
